dmem_responder: RTL and testbench

//  Handshaked data-memory responder: the target end of the CPU's load/store port.

---
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder for the CPU load/store port: one request at a time,
// fixed wait latency, then a valid/ready response. `DMEM_RANGE_CHECK_EN enables address error reporting.
module dmem_responder #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                wr_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;
  logic                err_d;
  logic                lat_en;
  logic                mem_we;
  logic                rsp_valid_nx;
  logic [DATA_W-1:0]   rsp_rdata_nx;
  logic                rsp_err_nx;

  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef DMEM_RANGE_CHECK_EN
  assign err_d = (req_addr >= DATA_W'(DEPTH));
`else
  // Upper address bits alias onto the array; they are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr[DATA_W-1:ADDR_W];
  assign err_d       = 1'b0;
`endif

  // Next-state and response computation
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    lat_en       = 1'b0;
    mem_we       = 1'b0;
    rsp_valid_nx = rsp_valid;
    rsp_rdata_nx = rsp_rdata;
    rsp_err_nx   = rsp_err;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          lat_en   = 1'b1;
          cnt_nx   = CNT_W'(WAIT_CYCLES);
          state_nx = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_nx = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_we       = wr_q && !err_q;
        rsp_rdata_nx = (wr_q || err_q) ? '0 : mem[idx_q];
        rsp_err_nx   = err_q;
        rsp_valid_nx = 1'b1;
        state_nx     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          rsp_err_nx   = 1'b0;
          state_nx     = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, request latch and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      req_ready <= (state_nx == S_IDLE);
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
      if (lat_en) begin
        wr_q    <= req_write;
        idx_q   <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
        err_q   <= err_d;
      end
    end
  end

  // Array is not reset; a store only lands on the edge leaving ACCESS
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: u0 uses WAIT_CYCLES=2, u1 uses WAIT_CYCLES=0.
module tb_dmem_responder;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  int               cyc = 0;
  int               checks = 0;
  int               failures = 0;

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [31:0] EXP40_RD  = 32'h0;
  localparam logic        EXP40_ERR = 1'b1;
`else
  localparam logic [31:0] EXP40_RD  = 32'h0000_0011;
  localparam logic        EXP40_ERR = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(32), .ADDR_W(5), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(32), .ADDR_W(5), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  typedef struct {
    int          u;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       nm;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present a request on unit u and return the cycle index of the accepting edge.
  task automatic accept(input int u, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input string nm, output int a);
    bit ok;
    @(negedge clk);
    req_valid[u] = 1'b1; req_write[u] = wr; req_addr[u] = addr; req_wdata[u] = wdata;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready[u]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1 a = cyc;
  endtask

  task automatic wait_rsp(input int u, input int a, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid[u]) begin lat = cyc - a; break; end
    end
  endtask

  task automatic xact(input vec_t v);
    int a, lat, exp_lat;
    exp_lat = (v.u == 0) ? 3 : 1;
    rsp_ready[v.u] = 1'b1;
    accept(v.u, v.wr, v.addr, v.wdata, v.nm, a);
    req_valid[v.u] = 1'b0;
    wait_rsp(v.u, a, lat);
    chk({v.nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({v.nm, "_rdata"}, rsp_rdata[v.u], v.exp_rd);
    chk({v.nm, "_err"}, 32'(rsp_err[v.u]), 32'(v.exp_err));
    @(posedge clk);
    #1 chk({v.nm, "_drop"}, 32'(rsp_valid[v.u]), 32'd0);
  endtask

  initial begin
    int a, lat, t0, t1, n;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;

    // Async reset mid-clock
    #3 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst%0d_req_ready", u), 32'(req_ready[u]), 32'd1);
      chk($sformatf("rst%0d_rsp_valid", u), 32'(rsp_valid[u]), 32'd0);
      chk($sformatf("rst%0d_rsp_rdata", u), rsp_rdata[u], 32'd0);
      chk($sformatf("rst%0d_rsp_err", u), 32'(rsp_err[u]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    tv.push_back('{0, 1'b1, 32'd5,  32'h1234_ABCD, 32'h0,         1'b0, "st5"});
    tv.push_back('{0, 1'b0, 32'd5,  32'h0,         32'h1234_ABCD, 1'b0, "ld5"});
    tv.push_back('{0, 1'b1, 32'd7,  32'hAAAA_5555, 32'h0,         1'b0, "st7"});
    tv.push_back('{0, 1'b1, 32'd8,  32'h0000_0011, 32'h0,         1'b0, "st8"});
    tv.push_back('{0, 1'b1, 32'd3,  32'h0BAD_CAFE, 32'h0,         1'b0, "st3"});
    tv.push_back('{0, 1'b1, 32'd31, 32'hDEAD_BEEF, 32'h0,         1'b0, "st31"});
    tv.push_back('{0, 1'b0, 32'd31, 32'h0,         32'hDEAD_BEEF, 1'b0, "ld31"});
    tv.push_back('{0, 1'b0, 32'd7,  32'h0,         32'hAAAA_5555, 1'b0, "ld7"});
    tv.push_back('{0, 1'b1, 32'd5,  32'h0000_0055, 32'h0,         1'b0, "st5b"});
    tv.push_back('{0, 1'b0, 32'd5,  32'h0,         32'h0000_0055, 1'b0, "ld5b"});
    tv.push_back('{0, 1'b0, 32'd8,  32'h0,         32'h0000_0011, 1'b0, "ld8"});
    tv.push_back('{0, 1'b0, 32'd40, 32'h0,         EXP40_RD,      EXP40_ERR, "ld40"});
    tv.push_back('{1, 1'b1, 32'd0,  32'hCAFE_F00D, 32'h0,         1'b0, "w0_st0"});
    tv.push_back('{1, 1'b0, 32'd0,  32'h0,         32'hCAFE_F00D, 1'b0, "w0_ld0"});
    tv.push_back('{1, 1'b1, 32'd1,  32'h0F0F_1234, 32'h0,         1'b0, "w0_st1"});
    tv.push_back('{1, 1'b0, 32'd1,  32'h0,         32'h0F0F_1234, 1'b0, "w0_ld1"});
    foreach (tv[i]) xact(tv[i]);

    // Backpressure: load 3 held 4 cycles while a second request waits
    rsp_ready[0] = 1'b0;
    accept(0, 1'b0, 32'd3, 32'h0, "bp", a);
    req_addr[0] = 32'd5;
    wait_rsp(0, a, lat);
    chk("bp_lat", 32'(lat), 32'd3);
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_hold_rdata", rsp_rdata[0], 32'h0BAD_CAFE);
      chk("bp_hold_ready", 32'(req_ready[0]), 32'd0);
      if (k < 3) @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_gap_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp_gap_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    #1 a = cyc;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp_second_busy", 32'(req_ready[0]), 32'd0);
    wait_rsp(0, a, lat);
    chk("bp_second_lat", 32'(lat), 32'd3);
    chk("bp_second_rdata", rsp_rdata[0], 32'h0000_0055);
    @(posedge clk);

    // Zero-wait unit: back-to-back loads with req_valid held
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'd0;
    n = 0; t0 = 0; t1 = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      if (req_ready[1]) begin
        if (n == 0) t0 = cyc + 1; else t1 = cyc + 1;
        n++;
      end
      if (n < 2) @(negedge clk);
    end
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    chk("b2b_spacing", 32'(t1 - t0), 32'd3);
    repeat (3) @(negedge clk);
    chk("b2b_idle", 32'(req_ready[1]), 32'd1);

    // Reset during WAIT discards the pending store
    accept(0, 1'b1, 32'd7, 32'h0, "rststore", a);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready[0]), 32'd1);
    chk("midrst_valid", 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xact('{0, 1'b0, 32'd7, 32'h0, 32'hAAAA_5555, 1'b0, "ld7_after_rst"});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
